// File: rtl/omsp_spm_key_sequencer.sv
// Loads a newly created SM's key into the SPM array. Key words arrive from the
// key-derivation unit and are written one word per write strobe. The CPU is stalled while busy.
module omsp_spm_key_sequencer #(
    parameter int KEY_IDX_SIZE = 2,
    parameter int KEY_WORDS    = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    i_mclk,
    input  logic                    i_puc_rst,
    input  logic                    i_start,
    input  logic [15:0]             i_start_id,
    input  logic                    i_abort,
    output logic                    o_kd_start,
    input  logic                    i_kd_word_valid,
    input  logic [15:0]             i_kd_word,
    output logic                    o_kd_word_ready,
    output logic                    o_write_key,
    output logic [15:0]             o_key_in,
    output logic [KEY_IDX_SIZE-1:0] o_key_idx,
    output logic [15:0]             o_sm_id,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [2:0]              o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_WORDS - 1);
    localparam logic [15:0]             TO_LAST  = 16'(TIMEOUT - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [KEY_IDX_SIZE-1:0] r_idx;
    logic [15:0]             r_cnt;
    logic [15:0]             r_key_in;
    logic [KEY_IDX_SIZE-1:0] r_key_idx;
    logic [15:0]             r_sm_id;
    logic                    w_accept;

    // Handshake: a word transfers on a cycle where kd_word_valid and kd_word_ready
    // are both high at the rising edge; ready drops on abort so no word is consumed then.
    assign w_accept = (r_state == S_WAIT) && i_kd_word_valid && !i_abort;

    always_comb begin
        w_next          = r_state;
        o_kd_start      = 1'b0;
        o_kd_word_ready = 1'b0;
        o_write_key     = 1'b0;
        o_done          = 1'b0;
        o_error         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_START;
            end
            S_START: begin
                o_kd_start = 1'b1;
                w_next     = i_abort ? S_ERR : S_WAIT;
            end
            S_WAIT: begin
                o_kd_word_ready = !i_abort;
                if (i_abort)              w_next = S_ERR;
                else if (i_kd_word_valid) w_next = S_WRITE;
                else if (r_cnt == TO_LAST) w_next = S_ERR;
            end
            S_WRITE: begin
                o_write_key = !i_abort;
                if (i_abort)               w_next = S_ERR;
                else if (r_idx == LAST_IDX) w_next = S_DONE;
                else                        w_next = S_WAIT;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                o_error = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_mclk) begin
        if (i_puc_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_key_in  <= '0;
            r_key_idx <= '0;
            r_sm_id   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sm_id <= i_start_id;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_accept) begin
                        r_key_in  <= i_kd_word;
                        r_key_idx <= r_idx;
                    end else if (!i_abort) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WRITE: begin
                    // idx saturates at the last word; DONE follows instead of a wrap
                    if (!i_abort && r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_key_in    = r_key_in;
    assign o_key_idx   = r_key_idx;
    assign o_sm_id     = r_sm_id;
    assign o_busy      = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_omsp_spm_key_sequencer.sv
// Directed and randomized checks of the SPM key sequencer against a cycle-timeline model
// derived from the handshake, timeout and abort rules.
module tb_omsp_spm_key_sequencer;
    localparam int KW  = 4;
    localparam int KIS = 2;
    localparam int TO  = 8;

    logic           clk = 1'b0;
    logic           puc_rst, start, abort, kd_word_valid;
    logic [15:0]    start_id, kd_word;
    logic           kd_start, kd_word_ready, write_key, busy, done, error;
    logic [15:0]    key_in, sm_id;
    logic [KIS-1:0] key_idx;
    logic [2:0]     dbg_state;

    omsp_spm_key_sequencer #(.KEY_IDX_SIZE(KIS), .KEY_WORDS(KW), .TIMEOUT(TO)) dut (
        .i_mclk(clk), .i_puc_rst(puc_rst), .i_start(start), .i_start_id(start_id),
        .i_abort(abort), .o_kd_start(kd_start), .i_kd_word_valid(kd_word_valid),
        .i_kd_word(kd_word), .o_kd_word_ready(kd_word_ready), .o_write_key(write_key),
        .o_key_in(key_in), .o_key_idx(key_idx), .o_sm_id(sm_id), .o_busy(busy),
        .o_done(done), .o_error(error), .o_dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: records every strobe with its cycle
    typedef struct { int cyc; logic [15:0] idx; logic [15:0] word; } wr_t;
    wr_t wr_q[$];
    int  done_q[$], err_q[$], kds_q[$];
    int  acc_n = 0, wr_total = 0, hs_viol = 0;

    always @(negedge clk) begin
        acc_n <= acc_n + ((kd_word_valid && kd_word_ready) ? 1 : 0);
        if (write_key) begin
            if (wr_total >= acc_n) hs_viol <= hs_viol + 1;
            wr_total <= wr_total + 1;
            wr_q.push_back('{cyc, 16'(key_idx), key_in});
        end
        if (done)     done_q.push_back(cyc);
        if (error)    err_q.push_back(cyc);
        if (kd_start) kds_q.push_back(cyc);
    end

    // scoreboard
    int vectors = 0, miscompares = 0;
    logic [47:0] exp_q[$];
    int exp_done, exp_err, exp_idle;
    logic [15:0] pw[KW];
    int          pg[KW];
    int          base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timeline model: word k becomes valid 1+gap cycles after its predecessor's
    // acceptance (cycle 1 for word 0); a WAIT window is TO cycles long.
    task automatic model(input int abort_rel);
        int a, w, rise, fin;
        exp_q.delete();
        exp_done = -1;
        exp_err  = -1;
        a = 0;
        for (int k = 0; k < KW; k++) begin
            w    = (k == 0) ? 2 : a + 2;
            rise = (k == 0) ? 1 + pg[0] : a + 1 + pg[k];
            if (rise - w >= TO) begin
                exp_err = w + TO;
                break;
            end
            a = (rise > w) ? rise : w;
            exp_q.push_back({16'(a + 1), 16'(k), pw[k]});
        end
        if (exp_err < 0) exp_done = a + 2;
        fin = (exp_err > 0) ? exp_err : exp_done;
        if (abort_rel >= 1 && abort_rel < fin) begin
            while (exp_q.size() > 0 && int'(exp_q[$][47:32]) >= abort_rel) void'(exp_q.pop_back());
            exp_done = -1;
            exp_err  = abort_rel + 1;
            fin      = exp_err;
        end
        exp_idle = fin + 1;
    endtask

    task automatic launch(input logic [15:0] id);
        start    = 1'b1;
        start_id = id;
        tick();
        base     = cyc;
        start    = 1'b0;
        start_id = 16'($urandom);
    endtask

    // drives the producer and side inputs cycle by cycle until busy falls
    task automatic run(input int abort_rel, input int start_rel, input int rst_rel,
                       input logic [15:0] sid2, output int idle_rel);
        int k, g;
        logic stop;
        k = 0;
        g = pg[0];
        idle_rel = -1;
        stop = 1'b0;
        for (int c = 0; c < 400 && !stop; c++) begin
            abort    = (c + 1 == abort_rel);
            start    = (c + 1 == start_rel);
            start_id = (c + 1 == start_rel) ? sid2 : 16'($urandom);
            puc_rst  = (c + 1 == rst_rel);
            if (k >= KW || g > 0) begin
                kd_word_valid = 1'b0;
                kd_word       = 16'($urandom);
                if (g > 0) g--;
            end else begin
                kd_word_valid = 1'b1;
                kd_word       = pw[k];
            end
            @(negedge clk);
            if (!busy) begin
                idle_rel = cyc - base + 1;
                stop     = 1'b1;
            end else if (kd_word_valid && kd_word_ready) begin
                k++;
                if (k < KW) g = pg[k];
            end
            tick();
        end
        abort = 1'b0; start = 1'b0; puc_rst = 1'b0; kd_word_valid = 1'b0;
    endtask

    task automatic verify(input string tag, input int w0, input int d0, input int e0,
                          input int s0, input int idle_rel, input logic [15:0] id);
        int nw;
        nw = wr_q.size() - w0;
        check({tag, " nwrites"}, 64'(nw), 64'(exp_q.size()));
        for (int i = 0; i < nw && i < exp_q.size(); i++)
            check({tag, " write"}, {16'(wr_q[w0+i].cyc - base + 1), wr_q[w0+i].idx, wr_q[w0+i].word},
                  64'(exp_q[i]));
        check({tag, " ndone"}, 64'(done_q.size() - d0), (exp_done > 0) ? 64'd1 : 64'd0);
        if (exp_done > 0 && done_q.size() > d0)
            check({tag, " done_cyc"}, 64'(done_q[d0] - base + 1), 64'(exp_done));
        check({tag, " nerr"}, 64'(err_q.size() - e0), (exp_err > 0) ? 64'd1 : 64'd0);
        if (exp_err > 0 && err_q.size() > e0)
            check({tag, " err_cyc"}, 64'(err_q[e0] - base + 1), 64'(exp_err));
        check({tag, " nkdstart"}, 64'(kds_q.size() - s0), 64'd1);
        if (kds_q.size() > s0) check({tag, " kdstart_cyc"}, 64'(kds_q[s0] - base + 1), 64'd1);
        check({tag, " idle_cyc"}, 64'(idle_rel), 64'(exp_idle));
        check({tag, " sm_id"}, 64'(sm_id), 64'(id));
    endtask

    task automatic scenario(input string tag, input logic [15:0] id, input int abort_rel,
                            input int start_rel, input logic [15:0] sid2);
        int w0, d0, e0, s0, idle_rel;
        w0 = wr_q.size(); d0 = done_q.size(); e0 = err_q.size(); s0 = kds_q.size();
        model(abort_rel);
        launch(id);
        run(abort_rel, start_rel, 0, sid2, idle_rel);
        verify(tag, w0, d0, e0, s0, idle_rel, id);
    endtask

    initial begin
        int w0, d0, e0, s0, idle_rel;
        puc_rst = 1'b1; start = 1'b0; abort = 1'b0; kd_word_valid = 1'b0;
        start_id = '0; kd_word = '0;
        tick();
        tick();
        check("rst busy",      64'(busy),          64'd0);
        check("rst kd_start",  64'(kd_start),      64'd0);
        check("rst ready",     64'(kd_word_ready), 64'd0);
        check("rst write_key", 64'(write_key),     64'd0);
        check("rst key_in",    64'(key_in),        64'd0);
        check("rst key_idx",   64'(key_idx),       64'd0);
        check("rst sm_id",     64'(sm_id),         64'd0);
        check("rst done",      64'(done),          64'd0);
        check("rst error",     64'(error),         64'd0);
        check("rst state",     64'(dbg_state),     64'd0);
        puc_rst = 1'b0;
        tick();

        pw = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
        pg = '{0, 0, 0, 0};
        scenario("happy", 16'h0005, 0, 0, 16'h0);

        pg = '{5, 5, 5, 5};
        scenario("backpressure", 16'h0042, 0, 0, 16'h0);

        pg = '{1000, 0, 0, 0};
        scenario("timeout", 16'h0077, 0, 0, 16'h0);

        pg = '{8, 0, 0, 8};
        scenario("last_cycle_valid", 16'h0101, 0, 0, 16'h0);

        pg = '{9, 0, 0, 0};
        scenario("late_valid", 16'h0202, 0, 0, 16'h0);

        pg = '{0, 0, 0, 0};
        scenario("abort_write2", 16'h0303, 7, 0, 16'h0);

        pg = '{5, 5, 5, 5};
        scenario("start_busy", 16'h1234, 0, 4, 16'hBEEF);

        // reset in WAIT: idle next edge, nothing further
        pg = '{1000, 0, 0, 0};
        w0 = wr_q.size(); d0 = done_q.size(); e0 = err_q.size(); s0 = kds_q.size();
        launch(16'h5A5A);
        run(0, 0, 4, 16'h0, idle_rel);
        check("rst_wait idle_cyc", 64'(idle_rel), 64'd5);
        repeat (12) tick();
        check("rst_wait nwrites", 64'(wr_q.size() - w0),   64'd0);
        check("rst_wait ndone",   64'(done_q.size() - d0), 64'd0);
        check("rst_wait nerr",    64'(err_q.size() - e0),  64'd0);
        check("rst_wait nkds",    64'(kds_q.size() - s0),  64'd1);
        check("rst_wait sm_id",   64'(sm_id),   64'd0);
        check("rst_wait key_in",  64'(key_in),  64'd0);
        check("rst_wait busy",    64'(busy),    64'd0);

        for (int t = 0; t < 10; t++) begin
            int ab;
            for (int k = 0; k < KW; k++) begin
                pw[k] = 16'($urandom);
                pg[k] = $urandom_range(0, 9);
            end
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : 0;
            scenario($sformatf("rand%0d", t), 16'($urandom), ab, 0, 16'h0);
        end

        check("handshake violations", 64'(hs_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
